// File: rtl/alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_stage
// Purpose  : Multi-lane ALU control decode stage with a two-entry
//            (output + skid) buffer and a saturating illegal-lane counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_stage #(
    parameter int LANES = 2,
    parameter int TAG_W = 6,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_lane_valid,
    input  logic [2*LANES-1:0]       alu_op,
    input  logic [3*LANES-1:0]       funct3,
    input  logic [7*LANES-1:0]       funct7,
    input  logic [TAG_W*LANES-1:0]   in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_lane_valid,
    output logic [TAG_W*LANES-1:0]   out_tag,
    output logic [4*LANES-1:0]       alu_control,
    output logic [2*LANES-1:0]       mem_size,
    output logic [LANES-1:0]         mem_unsigned,
    output logic [LANES-1:0]         illegal,
    input  logic                     clear_count,
    output logic [CNT_W-1:0]         illegal_count
);

    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_XOR  = 4'b0011;
    localparam logic [3:0] c_ALU_SLL  = 4'b0100;
    localparam logic [3:0] c_ALU_SRL  = 4'b0101;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_SRA  = 4'b0111;
    localparam logic [3:0] c_ALU_SLT  = 4'b1000;
    localparam logic [3:0] c_ALU_SLTU = 4'b1001;
    localparam logic [3:0] c_ALU_NONE = 4'b1111;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    // Packed bundle: {lane_valid, tag, alu_control, mem_size, mem_unsigned, illegal}
    localparam int c_BW = LANES * (TAG_W + 9);
    localparam logic [c_BW-1:0] c_RESET_DATA = {{LANES{1'b0}}, {(TAG_W*LANES){1'b0}},
                                                {(4*LANES){1'b1}}, {(2*LANES){1'b0}},
                                                {LANES{1'b0}}, {LANES{1'b0}}};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [4*LANES-1:0] w_dec_ctrl;
    logic [2*LANES-1:0] w_dec_size;
    logic [LANES-1:0]   w_dec_uns;
    logic [LANES-1:0]   w_dec_ill;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [1:0] w_op;
        logic [2:0] w_f3;
        logic [6:0] w_f7;
        logic       w_f7_bad;
        logic [3:0] w_ctrl;
        logic [1:0] w_size;
        logic       w_uns;
        logic       w_ill;

        assign w_op     = alu_op[2*i +: 2];
        assign w_f3     = funct3[3*i +: 3];
        assign w_f7     = funct7[7*i +: 7];
        // Only R-type encodings require funct7 to be zero; I-type keeps immediate bits there
        assign w_f7_bad = (w_op == 2'b10) && (w_f7 != c_F7_BASE);

        // Decode one lane's ALUOp/funct3/funct7 into control, memory size and legality
        always_comb begin
            w_ctrl = c_ALU_NONE;
            w_size = 2'b00;
            w_uns  = 1'b0;
            w_ill  = 1'b0;
            if (in_lane_valid[i]) begin
                case (w_op)
                    2'b00: begin
                        w_ctrl = c_ALU_ADD;
                        case (w_f3)
                            3'b000:  w_size = 2'b00;
                            3'b001:  w_size = 2'b01;
                            3'b010:  w_size = 2'b10;
                            3'b100:  begin w_size = 2'b00; w_uns = 1'b1; end
                            3'b101:  begin w_size = 2'b01; w_uns = 1'b1; end
                            default: w_ill = 1'b1;
                        endcase
                    end
                    2'b01:   w_ctrl = c_ALU_NONE;
                    default: begin
                        case (w_f3)
                            3'b000: begin
                                if ((w_op == 2'b10) && (w_f7 == c_F7_ALT)) begin
                                    w_ctrl = c_ALU_SUB;
                                end else begin
                                    w_ctrl = c_ALU_ADD;
                                    w_ill  = w_f7_bad;
                                end
                            end
                            3'b001: begin w_ctrl = c_ALU_SLL;  w_ill = (w_f7 != c_F7_BASE); end
                            3'b010: begin w_ctrl = c_ALU_SLT;  w_ill = w_f7_bad; end
                            3'b011: begin w_ctrl = c_ALU_SLTU; w_ill = w_f7_bad; end
                            3'b100: begin w_ctrl = c_ALU_XOR;  w_ill = w_f7_bad; end
                            3'b101: begin
                                if (w_f7 == c_F7_BASE)     w_ctrl = c_ALU_SRL;
                                else if (w_f7 == c_F7_ALT) w_ctrl = c_ALU_SRA;
                                else                       w_ill  = 1'b1;
                            end
                            3'b110:  begin w_ctrl = c_ALU_OR;  w_ill = w_f7_bad; end
                            default: begin w_ctrl = c_ALU_AND; w_ill = w_f7_bad; end
                        endcase
                    end
                endcase
                if (w_ill) begin
                    w_ctrl = c_ALU_NONE;
                    w_size = 2'b00;
                    w_uns  = 1'b0;
                end
            end
        end

        assign w_dec_ctrl[4*i +: 4] = w_ctrl;
        assign w_dec_size[2*i +: 2] = w_size;
        assign w_dec_uns[i]         = w_uns;
        assign w_dec_ill[i]         = w_ill;
    end

    logic             r_out_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [c_BW-1:0]  r_out_data;
    logic [c_BW-1:0]  r_skid_data;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_out_free;
    logic             w_load_from_skid;
    logic             w_load_from_in;
    logic             w_load_skid;
    logic [c_BW-1:0]  w_new_data;
    logic [2:0]       w_ill_cnt;
    logic [CNT_W+2:0] w_cnt_sum;

    assign w_accept         = in_valid && r_in_ready;
    assign w_out_free       = !r_out_valid || out_ready;
    assign w_load_from_skid = r_skid_valid && out_ready;
    assign w_load_from_in   = w_accept && w_out_free;
    assign w_load_skid      = w_accept && !w_out_free;
    assign w_new_data       = {in_lane_valid, in_tag, w_dec_ctrl, w_dec_size, w_dec_uns, w_dec_ill};

    // Count the illegal lanes of the offered bundle (invalid lanes are never illegal)
    always_comb begin
        w_ill_cnt = 3'b000;
        for (int k = 0; k < LANES; k++) begin
            w_ill_cnt = w_ill_cnt + {2'b00, w_dec_ill[k]};
        end
    end

    assign w_cnt_sum = {3'b000, r_count} + {{CNT_W{1'b0}}, w_ill_cnt};

    // Output register plus skid register; in_ready is registered as "skid will be empty"
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_data   <= c_RESET_DATA;
            r_skid_data  <= c_RESET_DATA;
        end else begin
            if (w_load_from_skid) begin
                r_out_data  <= r_skid_data;
                r_out_valid <= 1'b1;
            end else if (w_load_from_in) begin
                r_out_data  <= w_new_data;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_load_skid) begin
                r_skid_data <= w_new_data;
            end
            r_skid_valid <= w_load_skid || (r_skid_valid && !out_ready);
            r_in_ready   <= !(w_load_skid || (r_skid_valid && !out_ready));
        end
    end

    // Saturating illegal-lane counter; clear overrides same-cycle increments
    always_ff @(posedge clk) begin
        if (reset || clear_count) begin
            r_count <= '0;
        end else if (w_accept) begin
            if (w_cnt_sum > {3'b000, c_CNT_MAX}) r_count <= c_CNT_MAX;
            else                                 r_count <= w_cnt_sum[CNT_W-1:0];
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign illegal_count = r_count;
    assign {out_lane_valid, out_tag, alu_control, mem_size, mem_unsigned, illegal} = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl_stage
// Purpose  : Scoreboard-based self-checking bench for alu_ctrl_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_stage;
    localparam int LANES = 2;
    localparam int TAG_W = 6;
    localparam int CNT_W = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES-1:0]       in_lane_valid;
    logic [2*LANES-1:0]     alu_op;
    logic [3*LANES-1:0]     funct3;
    logic [7*LANES-1:0]     funct7;
    logic [TAG_W*LANES-1:0] in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES-1:0]       out_lane_valid;
    logic [TAG_W*LANES-1:0] out_tag;
    logic [4*LANES-1:0]     alu_control;
    logic [2*LANES-1:0]     mem_size;
    logic [LANES-1:0]       mem_unsigned;
    logic [LANES-1:0]       illegal;
    logic                   clear_count;
    logic [CNT_W-1:0]       illegal_count;

    alu_ctrl_stage #(.LANES(LANES), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid), .out_tag(out_tag), .alu_control(alu_control),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .illegal(illegal),
        .clear_count(clear_count), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LANES-1:0]       lv;
        logic [TAG_W*LANES-1:0] tag;
        logic [4*LANES-1:0]     ctrl;
        logic [2*LANES-1:0]     size;
        logic [LANES-1:0]       uns;
        logic [LANES-1:0]       ill;
    } bundle_t;

    bundle_t sb_q[$];
    int n_vec = 0;
    int n_err = 0;

    // Reference decode of one lane: returns {ctrl, size, unsigned, illegal}
    function automatic logic [7:0] exp_lane(input logic lv, input logic [1:0] op,
                                            input logic [2:0] f3, input logic [6:0] f7);
        logic [3:0] tbl [8];
        logic [3:0] c;
        logic       ok;
        tbl = '{4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
        if (!lv) return {4'hF, 4'b0000};
        if (op == 2'b01) return {4'hF, 4'b0000};
        if (op == 2'b00) begin
            case (f3)
                3'd0:    return {4'b0010, 2'b00, 1'b0, 1'b0};
                3'd1:    return {4'b0010, 2'b01, 1'b0, 1'b0};
                3'd2:    return {4'b0010, 2'b10, 1'b0, 1'b0};
                3'd4:    return {4'b0010, 2'b00, 1'b1, 1'b0};
                3'd5:    return {4'b0010, 2'b01, 1'b1, 1'b0};
                default: return {4'hF, 3'b000, 1'b1};
            endcase
        end
        c = tbl[f3];
        if (f3 == 3'd1) begin
            ok = (f7 == 7'h00);
        end else if (f3 == 3'd5) begin
            ok = (f7 == 7'h00) || (f7 == 7'h20);
            if (f7 == 7'h20) c = 4'b0111;
        end else if (op == 2'b11) begin
            ok = 1'b1;
        end else begin
            ok = (f7 == 7'h00) || (f3 == 3'd0 && f7 == 7'h20);
            if (f3 == 3'd0 && f7 == 7'h20) c = 4'b0110;
        end
        return ok ? {c, 4'b0000} : {4'hF, 3'b000, 1'b1};
    endfunction

    function automatic bundle_t make_expected();
        bundle_t    b;
        logic [7:0] r;
        b.lv  = in_lane_valid;
        b.tag = in_tag;
        for (int i = 0; i < LANES; i++) begin
            r = exp_lane(in_lane_valid[i], alu_op[2*i +: 2], funct3[3*i +: 3], funct7[7*i +: 7]);
            b.ctrl[4*i +: 4] = r[7:4];
            b.size[2*i +: 2] = r[3:2];
            b.uns[i]         = r[1];
            b.ill[i]         = r[0];
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bundle();
        in_lane_valid = LANES'($urandom);
        alu_op        = (2*LANES)'($urandom);
        funct3        = (3*LANES)'($urandom);
        in_tag        = (TAG_W*LANES)'($urandom);
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(0, 2))
                0:       funct7[7*i +: 7] = 7'h00;
                1:       funct7[7*i +: 7] = 7'h20;
                default: funct7[7*i +: 7] = 7'($urandom);
            endcase
        end
    endtask

    // Scoreboard: push at acceptance, pop and compare at output handshake
    task automatic sb_monitor();
        bundle_t got;
        bundle_t exp;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    got = {out_lane_valid, out_tag, alu_control, mem_size, mem_unsigned, illegal};
                    n_vec++;
                    if (sb_q.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected_bundle: got %h required no bundle", got);
                    end else begin
                        exp = sb_q.pop_front();
                        if (got !== exp) begin
                            n_err++;
                            $display("FAIL sb_bundle: got %h required %h", got, exp);
                        end
                    end
                end
                if (in_valid && in_ready) sb_q.push_back(make_expected());
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_count = 1'b0;
        in_lane_valid = '0; alu_op = '0; funct3 = '0; funct7 = '0; in_tag = '0;
        repeat (3) step();
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        n_vec++; if (alu_control !== 8'hFF) begin n_err++; $display("FAIL reset_alu_control: got %h required ff", alu_control); end
        n_vec++; if ({out_lane_valid, out_tag, mem_size, mem_unsigned, illegal, illegal_count} !== '0) begin
            n_err++; $display("FAIL reset_other_outputs: got %h required 0",
                              {out_lane_valid, out_tag, mem_size, mem_unsigned, illegal, illegal_count});
        end
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_decode();
        step();
        out_ready = 1'b1; in_valid = 1'b1; in_lane_valid = 2'b11;
        alu_op = {2'b00, 2'b10}; funct3 = {3'b101, 3'b000}; funct7 = {7'h00, 7'h20};
        in_tag = {6'd11, 6'd10};
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL decode_latency: got out_valid %b required 1", out_valid); end
        n_vec++; if (alu_control !== 8'b0010_0110) begin n_err++; $display("FAIL decode_alu_control: got %b required 00100110", alu_control); end
        n_vec++; if (mem_size !== 4'b0100) begin n_err++; $display("FAIL decode_mem_size: got %b required 0100", mem_size); end
        n_vec++; if (mem_unsigned !== 2'b10) begin n_err++; $display("FAIL decode_mem_unsigned: got %b required 10", mem_unsigned); end
    endtask

    task automatic test_illegal();
        step();
        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        @(negedge clk);
        n_vec++; if (illegal_count !== 2'd0) begin n_err++; $display("FAIL illegal_count_before: got %0d required 0", illegal_count); end
        step();
        in_valid = 1'b1; in_lane_valid = 2'b01;
        alu_op = {2'b00, 2'b11}; funct3 = {3'b000, 3'b001}; funct7 = {7'h00, 7'h20};
        in_tag = {6'd21, 6'd20};
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (illegal !== 2'b01) begin n_err++; $display("FAIL illegal_flag: got %b required 01", illegal); end
        n_vec++; if (alu_control[3:0] !== 4'hF) begin n_err++; $display("FAIL illegal_ctrl: got %b required 1111", alu_control[3:0]); end
        n_vec++; if (illegal_count !== 2'd1) begin n_err++; $display("FAIL illegal_count_after: got %0d required 1", illegal_count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            step();
            out_ready = 1'b1; in_valid = 1'b1;
            rand_bundle();
            @(negedge clk);
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b required 1", i, in_ready); end
            if (i > 0) begin
                n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_out_valid[%0d]: got %b required 1", i, out_valid); end
            end
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        bundle_t exp_a;
        step(); step();
        out_ready = 1'b0; in_valid = 1'b1; in_lane_valid = 2'b11;
        alu_op = {2'b11, 2'b10}; funct3 = {3'b100, 3'b111}; funct7 = {7'h15, 7'h00};
        in_tag = {6'd2, 6'd1};
        step();
        alu_op = {2'b10, 2'b00}; funct3 = {3'b101, 3'b010}; funct7 = {7'h20, 7'h00};
        in_tag = {6'd4, 6'd3};
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_second_accept: got in_ready %b required 1", in_ready); end
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_a = (sb_q.size() > 0) ? sb_q[0] : '0;
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b required 0", i, in_ready); end
            n_vec++; if ({out_lane_valid, out_tag, alu_control, mem_size, mem_unsigned, illegal} !== exp_a || out_valid !== 1'b1) begin
                n_err++; $display("FAIL bp_hold[%0d]: got %b/%h required 1/%h", i, out_valid,
                                  {out_lane_valid, out_tag, alu_control, mem_size, mem_unsigned, illegal}, exp_a);
            end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (out_tag !== {6'd2, 6'd1}) begin n_err++; $display("FAIL bp_order_a: got tag %h required %h", out_tag, {6'd2, 6'd1}); end
        step();
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || out_tag !== {6'd4, 6'd3}) begin
            n_err++; $display("FAIL bp_order_b: got %b/%h required 1/%h", out_valid, out_tag, {6'd4, 6'd3});
        end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_release: got %b required 1", in_ready); end
        step();
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b required 0", out_valid); end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt [3];
        exp_cnt = '{2'd2, 2'd3, 2'd3};
        step();
        out_ready = 1'b1; clear_count = 1'b1;
        step();
        clear_count = 1'b0; in_valid = 1'b1; in_lane_valid = 2'b11;
        alu_op = {2'b10, 2'b10}; funct3 = {3'b000, 3'b000}; funct7 = {7'h7F, 7'h7F};
        in_tag = {6'd31, 6'd30};
        for (int b = 0; b < 3; b++) begin
            step();
            if (b == 2) in_valid = 1'b0;
            @(negedge clk);
            n_vec++; if (illegal_count !== exp_cnt[b]) begin
                n_err++; $display("FAIL sat_count[%0d]: got %0d required %0d", b, illegal_count, exp_cnt[b]);
            end
        end
        step();
        in_valid = 1'b1; clear_count = 1'b1;
        step();
        in_valid = 1'b0; clear_count = 1'b0;
        @(negedge clk);
        n_vec++; if (illegal_count !== 2'd0) begin n_err++; $display("FAIL clear_priority: got %0d required 0", illegal_count); end
    endtask

    task automatic test_random();
        int guard;
        for (int i = 0; i < 300; i++) begin
            step();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rand_bundle();
        end
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (sb_q.size() != 0 && guard < 10) begin
            step();
            guard++;
        end
        @(negedge clk);
        n_vec++; if (sb_q.size() != 0) begin n_err++; $display("FAIL random_drain: got %0d pending required 0", sb_q.size()); end
    endtask

    task automatic test_reset_mid();
        step(); step();
        out_ready = 1'b0; in_valid = 1'b1; in_lane_valid = 2'b11;
        alu_op = {2'b01, 2'b11}; funct3 = 6'b000_000; funct7 = '0; in_tag = {6'd41, 6'd40};
        step();
        in_tag = {6'd43, 6'd42};
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_skid_full: got in_ready %b required 0", in_ready); end
        step();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                n_err++; $display("FAIL rst_mid_during[%0d]: got out_valid %b in_ready %b required 0 0", i, out_valid, in_ready);
            end
        end
        step();
        reset = 1'b0; out_ready = 1'b1;
        step();
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready: got %b required 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_stale[%0d]: got out_valid %b required 0", i, out_valid); end
            step();
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_count = 1'b0;
        in_lane_valid = '0; alu_op = '0; funct3 = '0; funct7 = '0; in_tag = '0;
        fork
            sb_monitor();
            begin
                #500000;
                $display("FAIL timeout: simulation exceeded time budget");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_decode();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 SHALL take parameter LANES, default 2, meaning the number of decode lanes per bundle (1..4).
REQ-002 SHALL take parameter TAG_W, default 6, meaning the width of the per-lane ROB tag carried with each lane.
REQ-003 SHALL take parameter CNT_W, default 8, meaning the width of the illegal-operation counter.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning the reset; it is synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, meaning a bundle is offered.
REQ-007 SHALL have port in_ready, output, 1, meaning the stage accepts a bundle this cycle.
REQ-008 SHALL have port in_lane_valid, input, LANES, meaning the per-lane occupancy mask.
REQ-009 SHALL have port alu_op, input, 2*LANES, meaning the per-lane ALUOp (lane i = bits [2i+1:2i]).
REQ-010 SHALL have port funct3, input, 3*LANES, meaning the per-lane funct3.
REQ-011 SHALL have port funct7, input, 7*LANES, meaning the per-lane funct7.
REQ-012 SHALL have port in_tag, input, TAG_W*LANES, meaning the per-lane tag.
REQ-013 SHALL have port out_valid, output, 1, meaning a decoded bundle is presented.
REQ-014 SHALL have port out_ready, input, 1, meaning the consumer takes the bundle.
REQ-015 SHALL have ports out_lane_valid (LANES), out_tag (TAG_W*LANES), alu_control (4*LANES), mem_size (2*LANES), mem_unsigned (LANES) and illegal (LANES), all outputs, meaning the registered decode results per lane.
REQ-016 SHALL have ports clear_count, input, 1, meaning counter clear; and illegal_count, output, CNT_W, meaning the saturating count of illegal lanes.

Function
REQ-017 SHALL decode ALUOp 00 (load/store) to ALUControl 0010 and set mem_size/mem_unsigned from funct3: 000 byte (00,0); 001 half (01,0); 010 word (10,0); 100 byte-u (00,1); 101 half-u (01,1); any other funct3 is illegal.
REQ-018 SHALL decode ALUOp 11 (I-type) by funct3: 000 ADD 0010; 010 SLT 1000; 011 SLTU 1001; 100 XOR 0011; 110 OR 0001; 111 AND 0000; 001 SLL 0100, legal only with funct7 0000000; 101 SRL 0101 with funct7 0000000 or SRA 0111 with funct7 0100000; any other funct7 with 001/101 is illegal.
REQ-019 SHALL decode ALUOp 10 (R-type) with the same funct3 mapping as REQ-018, additionally 000 with funct7 0100000 = SUB 0110; funct7 is required to be 0000000 for every other legal encoding; anything else is illegal.
REQ-020 SHALL decode ALUOp 01 (LUI) to ALUControl 1111 with illegal=0.
REQ-021 SHALL, for an illegal lane, output ALUControl 1111 and illegal=1; for every non-memory lane, output mem_size 00 and mem_unsigned 0.
REQ-022 SHALL force all decode outputs of a lane with in_lane_valid=0 to ALUControl 1111, illegal 0, mem fields 0, while still passing its tag.
REQ-023 SHALL accept a bundle on in_valid && in_ready; the bundle's results appear on the outputs with out_valid=1 exactly 1 cycle later when the output register is free.
REQ-024 SHALL buffer bundles in a two-entry structure (output register + skid register); in_ready = skid empty, driven from a register (no combinational path from out_ready).
REQ-025 SHALL, when a bundle is accepted while the output register holds data and out_ready=0, store it in the skid register; the skid entry moves to the output register on the next out_ready=1 cycle, preserving order.
REQ-026 SHALL hold all output fields stable while out_valid=1 and out_ready=0.
REQ-027 SHALL support simultaneous accept and drain (full throughput, one bundle/cycle, with skid empty).
REQ-028 SHALL add the number of accepted lanes with in_lane_valid=1 and illegal=1 to illegal_count at acceptance, saturating at 2^CNT_W-1.
REQ-029 SHALL, when clear_count=1, set illegal_count to 0 and discard the same cycle's increments.

Reset
REQ-030 SHALL, while reset=1 at a clock edge, set out_valid 0, skid empty, illegal_count 0, in_ready 0, alu_control all 1111, and all other outputs 0; in_ready is 1 in the first cycle after reset deasserts.
REQ-031 SHALL discard any buffered bundle when reset is asserted mid-operation; no partial bundle is emitted afterwards.

Verification
REQ-032 SHALL be checked: LANES=2, lane0 ALUOp 10/f3 000/f7 0100000, lane1 ALUOp 00/f3 101 -> next cycle alu_control {0010,0110}, mem_size lane1 01, mem_unsigned lane1 1.
REQ-033 SHALL be checked: ALUOp 11/f3 001/f7 0100000 on lane0 -> illegal[0]=1, ALUControl 1111, illegal_count 0->1.
REQ-034 SHALL be checked: out_ready=0 for 3 cycles with 2 bundles A,B offered -> A held on outputs, B in skid, in_ready=0; out_ready=1 -> A then B in order.
REQ-035 SHALL be checked: CNT_W=2, 3 bundles each with 2 illegal lanes -> illegal_count saturates at 3; clear_count with a concurrent illegal bundle -> illegal_count 0.
REQ-036 SHALL be checked: reset asserted with skid full -> out_valid 0, in_ready 0 during reset, in_ready 1 on the following cycle, and no stale bundle emitted.
